multi_phase_traffic_ctrl: RTL

//  Parametrised N-approach intersection controller: one green phase at a time, mandatory yellow and
//  all-red clearance, per-approach saturating queue counters, queue-actuated green between min/max

---
 rtl/multi_phase_traffic_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multi_phase_traffic_ctrl.sv
// N-approach intersection controller: queue-actuated green, round-robin service, emergency preemption.
// Optional pedestrian WALK phase is built when PED_CROSSING_EN is defined.
module multi_phase_traffic_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int QW         = 4,
  parameter int CW         = 8,
  parameter int T_GMIN     = 3,
  parameter int T_GMAX     = 12,
  parameter int T_YEL      = 2,
  parameter int T_CLR      = 2,
  parameter int T_DISCH    = 2,
  parameter int PW         = $clog2(NUM_PHASES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PHASES-1:0]    car_detected,
  input  logic                     emergency,
  input  logic [PW-1:0]            emg_phase,
`ifdef PED_CROSSING_EN
  input  logic                     ped_req,
  output logic                     ped_walk,
`endif
  output logic [3*NUM_PHASES-1:0]  lights,
  output logic [QW*NUM_PHASES-1:0] queue_count,
  output logic [PW-1:0]            active_phase,
  output logic                     in_emergency
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_GREEN,
    S_YELLOW,
    S_EMG_GREEN
`ifdef PED_CROSSING_EN
    , S_WALK
`endif
  } state_t;

  localparam logic [CW-1:0] CLR_END   = CW'(T_CLR - 1);
  localparam logic [CW-1:0] GMIN_END  = CW'(T_GMIN - 1);
  localparam logic [CW-1:0] GMAX_END  = CW'(T_GMAX - 1);
  localparam logic [CW-1:0] YEL_END   = CW'(T_YEL - 1);
  localparam logic [CW-1:0] DISCH_END = CW'(T_DISCH - 1);
  localparam logic [QW-1:0] Q_MAX     = '1;

  state_t        state, state_next;
  logic [CW-1:0] timer;
  logic [CW-1:0] dcnt;
  logic [QW-1:0] q [NUM_PHASES];
  logic [PW-1:0] active_next;
  logic [PW-1:0] emg_lat, emg_next;
  logic [PW-1:0] rr_pick, rr_cand;
  logic          rr_found;
  logic          green_on;
  int            rr_idx;

`ifdef PED_CROSSING_EN
  localparam logic [CW-1:0] WALK_END = CW'(4 * T_CLR - 1);
  logic ped_pend;
  logic ped_clr;
`endif

  assign green_on     = (state == S_GREEN) || (state == S_EMG_GREEN);
  assign in_emergency = (state == S_EMG_GREEN);

  // First waiting approach after the last served one, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = active_phase;
    rr_cand  = active_phase;
    rr_idx   = 0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      rr_idx = int'(active_phase) + k;
      if (rr_idx >= NUM_PHASES) rr_idx = rr_idx - NUM_PHASES;
      rr_cand = PW'(rr_idx);
      if (!rr_found && q[rr_cand] != '0) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_next  = state;
    active_next = active_phase;
    emg_next    = emg_lat;
`ifdef PED_CROSSING_EN
    ped_clr     = 1'b0;
`endif
    case (state)
      S_CLEAR: begin
        if (timer == CLR_END) begin
          if (emergency) begin
            state_next  = S_EMG_GREEN;
            active_next = emg_phase;
            emg_next    = emg_phase;
          end
`ifdef PED_CROSSING_EN
          else if (ped_pend) begin
            state_next = S_WALK;
          end
`endif
          else if (rr_found) begin
            state_next  = S_GREEN;
            active_next = rr_pick;
          end
        end
      end
      S_GREEN: begin
        if (emergency && emg_phase == active_phase) begin
          state_next = S_EMG_GREEN;
          emg_next   = emg_phase;
        end else if (emergency || timer == GMAX_END ||
                     (timer >= GMIN_END && q[active_phase] == '0)) begin
          state_next = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer == YEL_END) state_next = S_CLEAR;
      end
      S_EMG_GREEN: begin
        if (!emergency) state_next = S_YELLOW;
      end
`ifdef PED_CROSSING_EN
      S_WALK: begin
        if (emergency) begin
          state_next = S_CLEAR;
        end else if (timer == WALK_END) begin
          state_next = S_CLEAR;
          ped_clr    = 1'b1;
        end
      end
`endif
      default: state_next = S_CLEAR;
    endcase
  end

  // Timer restarts on every transition; the idle all-red state parks at its expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CLEAR;
      timer        <= '0;
      dcnt         <= '0;
      active_phase <= PW'(NUM_PHASES - 1);
      emg_lat      <= '0;
    end else begin
      state        <= state_next;
      active_phase <= active_next;
      emg_lat      <= emg_next;
      if (state_next != state)
        timer <= '0;
      else if (!(state == S_CLEAR && timer == CLR_END) && timer != '1)
        timer <= timer + 1'b1;
      if (state_next != state || !green_on || dcnt == DISCH_END)
        dcnt <= '0;
      else
        dcnt <= dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (green_on && active_phase == PW'(i)) begin
          if (dcnt == DISCH_END && q[i] != '0) q[i] <= q[i] - 1'b1;
        end else if (car_detected[i] && q[i] != Q_MAX) begin
          q[i] <= q[i] + 1'b1;
        end
      end
    end
  end

`ifdef PED_CROSSING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ped_pend <= 1'b0;
    else if (ped_req) ped_pend <= 1'b1;
    else if (ped_clr) ped_pend <= 1'b0;
  end

  assign ped_walk = (state == S_WALK);
`endif

  always_comb begin
    lights = {NUM_PHASES{3'b100}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (state == S_GREEN && active_phase == PW'(i))      lights[3*i +: 3] = 3'b001;
      else if (state == S_YELLOW && active_phase == PW'(i)) lights[3*i +: 3] = 3'b010;
      else if (state == S_EMG_GREEN && emg_lat == PW'(i))   lights[3*i +: 3] = 3'b001;
    end
  end

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_qout
    assign queue_count[QW*i +: QW] = q[i];
  end

endmodule
